// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the EX-stage sequencer and alu_mc.
// master = issuing side (operands, op, result consumer); slave = the execute unit.
interface alu_mc_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5,
  parameter int PC_W          = 9
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [PC_W-1:0]          Curr_Pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    ALUResult;

  modport master (
    output in_valid, SrcA, SrcB, Operation, Curr_Pc, out_ready,
    input  in_ready, out_valid, ALUResult
  );

  modport slave (
    input  in_valid, SrcA, SrcB, Operation, Curr_Pc, out_ready,
    output in_ready, out_valid, ALUResult
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage execute unit behind a valid/ready handshake.
// Base ops finish in one cycle; RV32M ops (optional, enabled by defining the
// macro ALU_MC_MDU_EN) run DATA_WIDTH iterations of shift-add multiply or
// restoring division on operand magnitudes, with the sign fixed on write-back.
module alu_mc #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5,
  parameter int PC_W          = 9
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  alu_mc_if.slave bus
);
  localparam int SH_W = $clog2(DATA_WIDTH);

  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONES = {DATA_WIDTH{1'b1}};

  localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = 5'd0;
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = 5'd1;
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = 5'd2;
  localparam logic [OPCODE_LENGTH-1:0] OP_OR    = 5'd3;
  localparam logic [OPCODE_LENGTH-1:0] OP_AND   = 5'd4;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = 5'd5;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA   = 5'd6;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL   = 5'd7;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = 5'd8;
  localparam logic [OPCODE_LENGTH-1:0] OP_LDST  = 5'd9;
  localparam logic [OPCODE_LENGTH-1:0] OP_NE    = 5'd10;
  localparam logic [OPCODE_LENGTH-1:0] OP_BLT   = 5'd11;
  localparam logic [OPCODE_LENGTH-1:0] OP_BGE   = 5'd12;
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ    = 5'd13;
  localparam logic [OPCODE_LENGTH-1:0] OP_PASSB = 5'd14;
  localparam logic [OPCODE_LENGTH-1:0] OP_PC4   = 5'd15;
`ifdef ALU_MC_MDU_EN
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = 5'd16;
  localparam logic [OPCODE_LENGTH-1:0] OP_MULH  = 5'd17;
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHU = 5'd18;
  localparam logic [OPCODE_LENGTH-1:0] OP_DIV   = 5'd19;
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU  = 5'd20;
  localparam logic [OPCODE_LENGTH-1:0] OP_REM   = 5'd21;
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU  = 5'd22;
  localparam logic [DATA_WIDTH-1:0]    MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MC_MDU_EN
    BUSY = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t                   state_r;
  logic                     out_valid_r;
  logic [DATA_WIDTH-1:0]    result_r;

  logic [DATA_WIDTH-1:0]    src_a_s;
  logic [DATA_WIDTH-1:0]    src_b_s;
  logic [OPCODE_LENGTH-1:0] op_s;
  logic [SH_W-1:0]          sh_amt_s;
  logic                     lt_s;
  logic                     eq_s;
  logic [PC_W-1:0]          pc_next_s;
  logic [DATA_WIDTH-1:0]    base_res_s;
  logic                     start_iter_s;

  assign src_a_s   = bus.SrcA;
  assign src_b_s   = bus.SrcB;
  assign op_s      = bus.Operation;
  assign sh_amt_s  = src_b_s[SH_W-1:0];
  assign lt_s      = $signed(src_a_s) < $signed(src_b_s);
  assign eq_s      = (src_a_s == src_b_s);
  assign pc_next_s = bus.Curr_Pc + 9'd4;

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.ALUResult = result_r;

`ifdef ALU_MC_MDU_EN
  logic                     div_zero_s;
  logic                     div_ovf_s;
  logic                     a_neg_s;
  logic                     b_neg_s;
  logic                     neg_fix_s;
  logic [DATA_WIDTH-1:0]    mag_a_s;
  logic [DATA_WIDTH-1:0]    mag_b_s;

  logic [OPCODE_LENGTH-1:0] op_r;
  logic                     neg_r;
  logic [DATA_WIDTH-1:0]    acc_r;
  logic [DATA_WIDTH-1:0]    opa_r;
  logic [DATA_WIDTH-1:0]    opb_r;
  logic [SH_W-1:0]          cnt_r;

  logic                     is_mul_s;
  logic [DATA_WIDTH:0]      mul_sum_s;
  logic [DATA_WIDTH-1:0]    mul_hi_next_s;
  logic [DATA_WIDTH-1:0]    mul_lo_next_s;
  logic [DATA_WIDTH:0]      div_shift_s;
  logic                     div_ge_s;
  logic [DATA_WIDTH-1:0]    div_rem_next_s;
  logic [DATA_WIDTH-1:0]    div_q_next_s;
  logic [DATA_WIDTH-1:0]    fin_res_s;

  assign div_zero_s = (src_b_s == ZERO);
  assign div_ovf_s  = (src_a_s == MOST_NEG) && (src_b_s == ONES);

  // Operand magnitudes and the sign to re-apply when the iterative result is written.
  always_comb begin
    a_neg_s   = 1'b0;
    b_neg_s   = 1'b0;
    neg_fix_s = 1'b0;
    if ((op_s == OP_MULH) || (op_s == OP_DIV) || (op_s == OP_REM)) begin
      a_neg_s = src_a_s[DATA_WIDTH-1];
      b_neg_s = src_b_s[DATA_WIDTH-1];
    end else begin
      a_neg_s = 1'b0;
      b_neg_s = 1'b0;
    end
    if (op_s == OP_REM) begin
      neg_fix_s = a_neg_s;
    end else begin
      neg_fix_s = a_neg_s ^ b_neg_s;
    end
    mag_a_s = a_neg_s ? -src_a_s : src_a_s;
    mag_b_s = b_neg_s ? -src_b_s : src_b_s;
  end

  // One iteration step: shift-add multiply on {acc,opb}, restoring divide on {acc,opa}.
  always_comb begin
    is_mul_s       = (op_r == OP_MUL) || (op_r == OP_MULH) || (op_r == OP_MULHU);
    mul_sum_s      = {1'b0, acc_r} + (opb_r[0] ? {1'b0, opa_r} : {1'b0, ZERO});
    mul_hi_next_s  = mul_sum_s[DATA_WIDTH:1];
    mul_lo_next_s  = {mul_sum_s[0], opb_r[DATA_WIDTH-1:1]};
    div_shift_s    = {acc_r, opa_r[DATA_WIDTH-1]};
    div_ge_s       = (div_shift_s >= {1'b0, opb_r});
    div_rem_next_s = div_ge_s ? (div_shift_s[DATA_WIDTH-1:0] - opb_r)
                              : div_shift_s[DATA_WIDTH-1:0];
    div_q_next_s   = {opa_r[DATA_WIDTH-2:0], div_ge_s};
  end

  // Sign-corrected result selected from the values produced by the final iteration.
  always_comb begin
    fin_res_s = ZERO;
    case (op_r)
      OP_MUL:   fin_res_s = mul_lo_next_s;
      OP_MULH:  fin_res_s = neg_r ? (~mul_hi_next_s +
                              {{(DATA_WIDTH-1){1'b0}}, (mul_lo_next_s == ZERO)})
                                  : mul_hi_next_s;
      OP_MULHU: fin_res_s = mul_hi_next_s;
      OP_DIV:   fin_res_s = neg_r ? -div_q_next_s : div_q_next_s;
      OP_DIVU:  fin_res_s = div_q_next_s;
      OP_REM:   fin_res_s = neg_r ? -div_rem_next_s : div_rem_next_s;
      OP_REMU:  fin_res_s = div_rem_next_s;
      default:  fin_res_s = ZERO;
    endcase
  end
`endif

  // Single-cycle result for base ops and division corner cases; flags iterative M ops.
  always_comb begin
    base_res_s   = ZERO;
    start_iter_s = 1'b0;
    case (op_s)
      OP_ADD:         base_res_s = src_a_s + src_b_s;
      OP_SUB:         base_res_s = src_a_s - src_b_s;
      OP_XOR:         base_res_s = src_a_s ^ src_b_s;
      OP_OR:          base_res_s = src_a_s | src_b_s;
      OP_AND:         base_res_s = src_a_s & src_b_s;
      OP_SLT, OP_BLT: base_res_s = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      OP_SRA:         base_res_s = $signed(src_a_s) >>> sh_amt_s;
      OP_SRL:         base_res_s = src_a_s >> sh_amt_s;
      OP_SLL:         base_res_s = src_a_s << sh_amt_s;
      OP_LDST:        base_res_s = ZERO;
      OP_NE:          base_res_s = {{(DATA_WIDTH-1){1'b0}}, ~eq_s};
      OP_BGE:         base_res_s = {{(DATA_WIDTH-1){1'b0}}, ~lt_s};
      OP_EQ:          base_res_s = {{(DATA_WIDTH-1){1'b0}}, eq_s};
      OP_PASSB:       base_res_s = src_b_s;
      OP_PC4:         base_res_s = {{(DATA_WIDTH-PC_W){1'b0}}, pc_next_s};
`ifdef ALU_MC_MDU_EN
      OP_MUL, OP_MULH, OP_MULHU: start_iter_s = 1'b1;
      OP_DIV: begin
        if (div_zero_s) begin
          base_res_s = ONES;
        end else if (div_ovf_s) begin
          base_res_s = MOST_NEG;
        end else begin
          start_iter_s = 1'b1;
        end
      end
      OP_DIVU: begin
        if (div_zero_s) begin
          base_res_s = ONES;
        end else begin
          start_iter_s = 1'b1;
        end
      end
      OP_REM: begin
        if (div_zero_s) begin
          base_res_s = src_a_s;
        end else if (div_ovf_s) begin
          base_res_s = ZERO;
        end else begin
          start_iter_s = 1'b1;
        end
      end
      OP_REMU: begin
        if (div_zero_s) begin
          base_res_s = src_a_s;
        end else begin
          start_iter_s = 1'b1;
        end
      end
`endif
      default:        base_res_s = ZERO;
    endcase
  end

  // Control FSM with registered result/valid and, when present, the iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      result_r    <= ZERO;
`ifdef ALU_MC_MDU_EN
      op_r        <= 5'd0;
      neg_r       <= 1'b0;
      acc_r       <= ZERO;
      opa_r       <= ZERO;
      opb_r       <= ZERO;
      cnt_r       <= {SH_W{1'b0}};
`endif
    end else if (flush) begin
      // Abort wins over accept/consume; the stale result stays visible but invalid.
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
`ifdef ALU_MC_MDU_EN
      cnt_r       <= {SH_W{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
`ifdef ALU_MC_MDU_EN
            if (start_iter_s) begin
              state_r <= BUSY;
              op_r    <= op_s;
              neg_r   <= neg_fix_s;
              acc_r   <= ZERO;
              opa_r   <= mag_a_s;
              opb_r   <= mag_b_s;
              cnt_r   <= {SH_W{1'b0}};
            end else begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              result_r    <= base_res_s;
            end
`else
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            result_r    <= base_res_s;
`endif
          end
        end
`ifdef ALU_MC_MDU_EN
        BUSY: begin
          if (is_mul_s) begin
            acc_r <= mul_hi_next_s;
            opb_r <= mul_lo_next_s;
          end else begin
            acc_r <= div_rem_next_s;
            opa_r <= div_q_next_s;
          end
          if (cnt_r == SH_W'(DATA_WIDTH - 1)) begin
            cnt_r       <= {SH_W{1'b0}};
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            result_r    <= fin_res_s;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule
